// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Raster-scan timing master for the VGA display path. Produces the
//            col/row/valid scan for the compositor, registers the compositor
//            colour with forced blanking, and drives hsync/vsync. A one-clk
//            frame_tick marks the start of vertical blanking.
// Ports    : clk        - system clock
//            reset      - synchronous, active-high reset
//            col, row   - current raster position (registered counters)
//            valid      - position is inside the visible area
//            rgb_in     - compositor colour for the current col/row (RRGGBB)
//            rgb_out    - registered, blank-forced colour to the pins
//            hsync      - horizontal sync (polarity set by SYNC_ACTIVE)
//            vsync      - vertical sync (polarity set by SYNC_ACTIVE)
//            pix_en     - one-clk pixel-advance strobe
//            frame_tick - one-clk pulse at the start of vertical blanking
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter bit SYNC_ACTIVE = 1'b0,
    parameter int PIX_DIV     = 1
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] col,
    output logic [9:0] row,
    output logic       valid,
    input  logic [5:0] rgb_in,
    output logic [5:0] rgb_out,
    output logic       hsync,
    output logic       vsync,
    output logic       pix_en,
    output logic       frame_tick
);

    localparam int c_h_total = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int c_v_total = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // A divide-by-1 still needs a one-bit register that simply stays at 0.
    localparam int c_div_w = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [c_div_w-1:0] c_div_max = c_div_w'(PIX_DIV - 1);

    localparam logic [9:0] c_h_vis   = 10'(H_VISIBLE);
    localparam logic [9:0] c_v_vis   = 10'(V_VISIBLE);
    localparam logic [9:0] c_h_last  = 10'(c_h_total - 1);
    localparam logic [9:0] c_v_last  = 10'(c_v_total - 1);
    localparam logic [9:0] c_hs_beg  = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] c_hs_end  = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] c_vs_beg  = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] c_vs_end  = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    // Last line before blanking: wrapping h on this line lands on (0, V_VISIBLE).
    localparam logic [9:0] c_v_pre_blank = 10'(V_VISIBLE - 1);

    generate
        if (c_h_total > 1024 || c_v_total > 1024 || PIX_DIV < 1) begin : g_param_check
            $error("vga_timing_gen: totals must be <= 1024 and PIX_DIV >= 1");
        end
    endgenerate

    logic [c_div_w-1:0] r_div;
    logic [9:0]         r_h;
    logic [9:0]         r_v;
    logic [5:0]         r_rgb;
    logic               r_hs;
    logic               r_vs;
    logic               r_tick;

    logic               w_pix_en;
    logic               w_valid;
    logic               w_h_wrap;

    assign w_pix_en = (r_div == c_div_max);
    assign w_valid  = (r_h < c_h_vis) && (r_v < c_v_vis);
    assign w_h_wrap = (r_h == c_h_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div  <= '0;
            r_h    <= '0;
            r_v    <= '0;
            r_rgb  <= '0;
            r_hs   <= ~SYNC_ACTIVE;
            r_vs   <= ~SYNC_ACTIVE;
            r_tick <= 1'b0;
        end else begin
            r_div  <= w_pix_en ? '0 : r_div + 1'b1;
            // Evaluated every clk so the pulse is one clk wide at any PIX_DIV.
            r_tick <= w_pix_en && w_h_wrap && (r_v == c_v_pre_blank);

            if (w_pix_en) begin
                if (w_h_wrap) begin
                    r_h <= '0;
                    r_v <= (r_v == c_v_last) ? '0 : r_v + 10'd1;
                end else begin
                    r_h <= r_h + 10'd1;
                end

                // Output stage samples the current position, so it trails
                // col/row by exactly one pixel.
                r_rgb <= w_valid ? rgb_in : 6'd0;
                r_hs  <= ((r_h >= c_hs_beg) && (r_h < c_hs_end)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
                r_vs  <= ((r_v >= c_vs_beg) && (r_v < c_vs_end)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            end
        end
    end

    assign col        = r_h;
    assign row        = r_v;
    assign valid      = w_valid;
    assign rgb_out    = r_rgb;
    assign hsync      = r_hs;
    assign vsync      = r_vs;
    assign pix_en     = w_pix_en;
    assign frame_tick = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Purpose  : Self-checking bench for vga_timing_gen. Three instances: default
//            640x480 timing, and a small 30x15 raster at PIX_DIV=2 (positive
//            sync) and PIX_DIV=1 (negative sync). Expected outputs are derived
//            arithmetically from the count of clocks since the last reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    typedef struct {
        int hv, hf, hs, hb, vv, vf, vs, vb, d, sa;
    } timing_t;

    typedef struct {
        int         col, row;
        logic       valid, hs, vs, pe, ft;
        logic [5:0] rgb;
    } exp_t;

    localparam timing_t T0 = '{640, 16, 96, 48, 480, 10, 2, 33, 1, 0};
    localparam timing_t T1 = '{16, 4, 6, 4, 8, 2, 2, 3, 2, 1};
    localparam timing_t T2 = '{16, 4, 6, 4, 8, 2, 2, 3, 1, 0};

    localparam int N_CYCLES = 20000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, rst1, rst2;
    logic [5:0] rgb_in0, rgb_in1, rgb_in2;
    logic [9:0] col0, col1, col2, row0, row1, row2;
    logic [5:0] rgb0, rgb1, rgb2;
    logic       valid0, valid1, valid2, hs0, hs1, hs2, vs0, vs1, vs2;
    logic       pe0, pe1, pe2, ft0, ft1, ft2;

    vga_timing_gen u_dut0 (
        .clk(clk), .reset(rst0), .col(col0), .row(row0), .valid(valid0),
        .rgb_in(rgb_in0), .rgb_out(rgb0), .hsync(hs0), .vsync(vs0),
        .pix_en(pe0), .frame_tick(ft0)
    );

    vga_timing_gen #(
        .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
        .V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .SYNC_ACTIVE(1'b1), .PIX_DIV(2)
    ) u_dut1 (
        .clk(clk), .reset(rst1), .col(col1), .row(row1), .valid(valid1),
        .rgb_in(rgb_in1), .rgb_out(rgb1), .hsync(hs1), .vsync(vs1),
        .pix_en(pe1), .frame_tick(ft1)
    );

    vga_timing_gen #(
        .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
        .V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .SYNC_ACTIVE(1'b0), .PIX_DIV(1)
    ) u_dut2 (
        .clk(clk), .reset(rst2), .col(col2), .row(row2), .valid(valid2),
        .rgb_in(rgb_in2), .rgb_out(rgb2), .hsync(hs2), .vsync(vs2),
        .pix_en(pe2), .frame_tick(ft2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Compositor stand-in: rows with row[1] set are solid white, others show col[5:0].
    function automatic logic [5:0] pat(int c, int r);
        return r[1] ? 6'h3F : c[5:0];
    endfunction

    // Expected outputs c clocks after the last reset release.
    function automatic exp_t model(timing_t t, int c);
        exp_t e;
        int ht = t.hv + t.hf + t.hs + t.hb;
        int vt = t.vv + t.vf + t.vs + t.vb;
        int fr = ht * vt;
        int p  = c / t.d;          // pixel advances completed so far
        int pp = p % fr;
        int q, qc, qr;
        logic act = t.sa[0];
        e.col   = pp % ht;
        e.row   = pp / ht;
        e.valid = (e.col < t.hv) && (e.row < t.vv);
        e.pe    = ((c % t.d) == t.d - 1);
        e.ft    = (p >= 1) && ((c % t.d) == 0) && (pp == t.vv * ht);
        if (p == 0) begin
            e.rgb = 6'd0;
            e.hs  = ~act;
            e.vs  = ~act;
        end else begin
            q  = (p - 1) % fr;     // pixel the output stage is showing
            qc = q % ht;
            qr = q / ht;
            e.rgb = ((qc < t.hv) && (qr < t.vv)) ? pat(qc, qr) : 6'd0;
            e.hs  = (qc >= t.hv + t.hf && qc < t.hv + t.hf + t.hs) ? act : ~act;
            e.vs  = (qr >= t.vv + t.vf && qr < t.vv + t.vf + t.vs) ? act : ~act;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv, input int c);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s at count %0d: got %0d, expected %0d", name, c, act, expv);
        end
    endtask

    task automatic cmp_dut(input string tag, input timing_t t, input int c,
                           input logic [9:0] col, input logic [9:0] row, input logic valid,
                           input logic [5:0] rgb, input logic hs, input logic vs,
                           input logic pe, input logic ft);
        exp_t e = model(t, c);
        chk({tag, ".col"},        32'(col),   32'(e.col),   c);
        chk({tag, ".row"},        32'(row),   32'(e.row),   c);
        chk({tag, ".valid"},      32'(valid), 32'(e.valid), c);
        chk({tag, ".rgb_out"},    32'(rgb),   32'(e.rgb),   c);
        chk({tag, ".hsync"},      32'(hs),    32'(e.hs),    c);
        chk({tag, ".vsync"},      32'(vs),    32'(e.vs),    c);
        chk({tag, ".pix_en"},     32'(pe),    32'(e.pe),    c);
        chk({tag, ".frame_tick"}, 32'(ft),    32'(e.ft),    c);
    endtask

    int   c0, c1, c2;
    logic done1, done2;

    task automatic drive_rgb();
        exp_t e;
        e = model(T0, c0); rgb_in0 = pat(e.col, e.row);
        e = model(T1, c1); rgb_in1 = pat(e.col, e.row);
        e = model(T2, c2); rgb_in2 = pat(e.col, e.row);
    endtask

    // Hand-computed anchors that pin the model itself.
    task automatic pin_checks();
        if (c0 == 0)   chk("d0.pin_reset_col",   32'(col0), 0, c0);
        if (c0 == 0)   chk("d0.pin_reset_hs",    32'(hs0),  1, c0);
        if (c0 == 6)   chk("d0.pin_rgb_col5",    32'(rgb0), 5, c0);
        if (c0 == 640) chk("d0.pin_rgb_639",     32'(rgb0), 63, c0);
        if (c0 == 641) chk("d0.pin_rgb_blank",   32'(rgb0), 0, c0);
        if (c0 == 656) chk("d0.pin_hs_pre",      32'(hs0),  1, c0);
        if (c0 == 657) chk("d0.pin_hs_first",    32'(hs0),  0, c0);
        if (c0 == 752) chk("d0.pin_hs_last",     32'(hs0),  0, c0);
        if (c0 == 753) chk("d0.pin_hs_end",      32'(hs0),  1, c0);
        if (c0 == 800) chk("d0.pin_line_row",    32'(row0), 1, c0);
        if (c0 == 800) chk("d0.pin_line_col",    32'(col0), 0, c0);
        if (c1 == 0)   chk("d1.pin_reset_pe",    32'(pe1),  0, c1);
        if (c1 == 1)   chk("d1.pin_pe",          32'(pe1),  1, c1);
        if (c1 == 480) chk("d1.pin_tick",        32'(ft1),  1, c1);
        if (c1 == 481) chk("d1.pin_tick_width",  32'(ft1),  0, c1);
        if (c1 == 601) chk("d1.pin_vs_pre",      32'(vs1),  0, c1);
        if (c1 == 602) chk("d1.pin_vs_first",    32'(vs1),  1, c1);
        if (c2 == 0)   chk("d2.pin_reset_row",   32'(row2), 0, c2);
        if (c2 == 239) chk("d2.pin_tick_pre",    32'(ft2),  0, c2);
        if (c2 == 240) chk("d2.pin_tick",        32'(ft2),  1, c2);
        if (c2 == 300) chk("d2.pin_vs_pre",      32'(vs2),  1, c2);
        if (c2 == 301) chk("d2.pin_vs_first",    32'(vs2),  0, c2);
        if (c2 == 361) chk("d2.pin_vs_end",      32'(vs2),  1, c2);
        if (c2 == 690) chk("d2.pin_tick2",       32'(ft2),  1, c2);
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        rgb_in0 = '0; rgb_in1 = '0; rgb_in2 = '0;
        done1 = 1'b0; done2 = 1'b0;
        c0 = 0; c1 = 0; c2 = 0;

        for (int i = 0; i < N_CYCLES; i++) begin
            @(posedge clk);
            #1;
            c0 = rst0 ? 0 : c0 + 1;
            c1 = rst1 ? 0 : c1 + 1;
            c2 = rst2 ? 0 : c2 + 1;
            rst0 = 1'b0;
            rst1 = 1'b0;
            rst2 = 1'b0;
            // One-shot mid-frame resets: dut1 mid-line, dut2 at col 20 row 5 of its second frame.
            if (!done1 && c1 == 1000) begin rst1 = 1'b1; done1 = 1'b1; end
            if (!done2 && c2 == 620)  begin rst2 = 1'b1; done2 = 1'b1; end
            drive_rgb();

            @(negedge clk);
            cmp_dut("d0", T0, c0, col0, row0, valid0, rgb0, hs0, vs0, pe0, ft0);
            cmp_dut("d1", T1, c1, col1, row1, valid1, rgb1, hs1, vs1, pe1, ft1);
            cmp_dut("d2", T2, c2, col2, row2, valid2, rgb2, hs2, vs2, pe2, ft2);
            pin_checks();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
